uart_tx_unit: RTL and testbench
===============================

// Module: uart_tx_unit
// PURPOSE
//  UART transmitter: serialises one byte per request as an 8N1 frame on tx_out.
//  Frame order: start bit (0), data LSB-first, stop bit (1).
//  Sits between a parallel byte source and the board TX pin; single clock domain.
// PARAMETERS
//  CLK_FREQ   50000000  system clock frequency, Hz
//  BAUD_RATE  9600      line rate, bit/s
//  Derived: BIT_TICKS = CLK_FREQ/BAUD_RATE (integer divide; 5208 at defaults)
// PORTS
//  clk       in   1  system clock; all logic on rising edge
//  rst       in   1  reset, synchronous, active-low
//  start_tx  in   1  transmit request, level-sampled in IDLE
//  data_tx   in   8  byte to send; captured when a request is accepted
//  tx_done   out  1  one-cycle pulse when the stop bit completes
//  tx_out    out  1  serial line; idle high
// BEHAVIOUR
//  - Reset (rst==0 at a clk edge): state=IDLE, tx_out=1, tx_done=0,
//    baud counter=0, bit index=0, shift register=0. Reset overrides everything.
//  - Reset mid-frame aborts the frame: tx_out=1 after that edge. No tx_done pulse.
//  - All outputs registered.
//  - FSM states: IDLE, START, DATA, STOP (plus PARITY, see CONFIGURATION).
//  - IDLE: tx_out=1. If start_tx=1 at an edge:
//    - latch data_tx into the shift register
//    - go to START; tx_out=0 from that edge
//  - START: hold 0 for BIT_TICKS cycles, then go to DATA with bit index 0.
//  - DATA: drive shift[idx] for BIT_TICKS cycles each, idx 0..7. After idx 7 go to STOP.
//  - STOP: drive 1 for BIT_TICKS cycles, then return to IDLE. tx_done=1 for exactly
//    that transition cycle.
//  - Baud counter: 0..BIT_TICKS-1; wraps to 0 at each bit boundary.
//    Width = $clog2(BIT_TICKS)+1.
//  - Frame length: exactly 10*BIT_TICKS cycles from acceptance to tx_done
//    (11*BIT_TICKS with parity).
//  - start_tx and data_tx are ignored outside IDLE. Changing data_tx mid-frame does
//    not affect the frame in progress.
//  - start_tx still high when IDLE is re-entered: a new frame is accepted on the next
//    edge (back-to-back frames, one idle-high cycle between them).
//  - start_tx and the tx_done cycle coincide: the request is accepted on the following
//    edge, as above.
// CONFIGURATION
//  - UART_TX_PARITY_EN defined: a PARITY state is inserted between DATA and STOP.
//    - drives the even parity bit (^data) for BIT_TICKS cycles
//    - frame becomes 8E1
//  - UART_TX_PARITY_EN undefined: no PARITY state; the frame is 8N1.
// TESTING
//  - Reset: hold rst=0 for 2 cycles -> tx_out=1, tx_done=0, line stays high with
//    start_tx=0.
//  - Send 0x55 (start_tx high 5 cycles) -> tx_out = 0,1,0,1,0,1,0,1,0,1.
//    Each level lasts 5208 cycles; tx_done pulses once, 52080 cycles after acceptance.
//  - Send 0x00 then 0xFF with start_tx held high ->
//    - two frames separated by one idle cycle
//    - data bits all 0, then all 1
//    - two tx_done pulses
//  - Change data_tx and pulse start_tx mid-frame -> no effect on the current frame;
//    no extra frame.
//  - Assert rst=0 during DATA bit 3 -> tx_out=1 next edge, no tx_done, FSM in IDLE.
//    A new 0xA5 frame then transmits correctly.
//  - UART_TX_PARITY_EN defined, send 0x07 -> parity bit=1 before stop bit;
//    tx_done at 57288 cycles.

Source files
------------

// File: rtl/uart_tx_unit.sv
// UART transmitter: one 8N1 frame (start, data LSB-first, stop) per accepted request.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit before stop (8E1).
module uart_tx_unit #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_tx,
    input  logic [7:0] data_tx,
    output logic       tx_done,
    output logic       tx_out
);

    localparam int unsigned BIT_TICKS = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W     = $clog2(BIT_TICKS) + 1;
    localparam int unsigned IDX_W     = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_TICKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(7);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_nxt;
    logic               r_tx_out;
    logic               w_tx_out_nxt;
    logic               r_tx_done;
    logic               w_tx_done_nxt;
    logic               w_bit_end;

    assign w_bit_end = (r_cnt == CNT_LAST);
    assign tx_out    = r_tx_out;
    assign tx_done   = r_tx_done;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_tx_out  <= 1'b1;
            r_tx_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_tx_out  <= w_tx_out_nxt;
            r_tx_done <= w_tx_done_nxt;
        end
    end

    // Next-state and next-output logic; the line level is computed one cycle ahead
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_shift_nxt   = r_shift;
        w_tx_out_nxt  = r_tx_out;
        w_tx_done_nxt = 1'b0;
        w_cnt_nxt     = (w_bit_end || (r_state == S_IDLE)) ? '0 : r_cnt + CNT_W'(1);

        case (r_state)
            S_IDLE: begin
                w_tx_out_nxt = 1'b1;
                w_idx_nxt    = '0;
                if (start_tx) begin
                    w_shift_nxt  = data_tx;
                    w_state_nxt  = S_START;
                    w_tx_out_nxt = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt  = S_DATA;
                    w_idx_nxt    = '0;
                    w_tx_out_nxt = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt  = S_PARITY;
                        w_tx_out_nxt = ^r_shift;
`else
                        w_state_nxt  = S_STOP;
                        w_tx_out_nxt = 1'b1;
`endif
                    end else begin
                        w_idx_nxt    = r_idx + IDX_W'(1);
                        w_tx_out_nxt = r_shift[r_idx + IDX_W'(1)];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt  = S_STOP;
                    w_tx_out_nxt = 1'b1;
                end
            end
`endif
            S_STOP: begin
                w_tx_out_nxt = 1'b1;
                if (w_bit_end) begin
                    w_state_nxt   = S_IDLE;
                    w_tx_done_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_tx_out_nxt = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed bench for uart_tx_unit with a short bit period (850/100 -> 8 clocks per bit).
// Expected line levels are built from the byte being sent; works with or without UART_TX_PARITY_EN.
module tb_uart_tx_unit;

    localparam int unsigned CLK_FREQ  = 850;
    localparam int unsigned BAUD_RATE = 100;
    localparam int T = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       start_tx = 1'b0;
    logic [7:0] data_tx  = 8'h00;
    logic       tx_done;
    logic       tx_out;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_unit #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start_tx(start_tx),
        .data_tx (data_tx),
        .tx_done (tx_done),
        .tx_out  (tx_out)
    );

    always #5 clk = ~clk;

    // Advance one clock; return on the falling edge where outputs are stable
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Frame slot k: 0 start, 1..8 data LSB first, optional even parity, then stop
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[3'(k - 1)];
        if (k == 9 && NBITS == 11) return ^b;
        return 1'b1;
    endfunction

    // Request byte b and check every cycle of the frame plus the tx_done cycle.
    // rel: step at which start_tx drops (-1 keeps it high); data_tx becomes mid_data
    // at step 1; pulse_at >= 0 raises start_tx for two cycles mid-frame.
    task automatic send_frame(input string name, input logic [7:0] b, input int rel,
                              input logic [7:0] mid_data, input int pulse_at);
        int good[11];
        int done_seen;
        done_seen = 0;
        for (int k = 0; k < 11; k++) good[k] = 0;
        data_tx  = b;
        start_tx = 1'b1;
        for (int s = 0; s <= NBITS * T; s++) begin
            tick();
            if (s < NBITS * T) begin
                if (tx_out === frame_bit(b, s / T)) good[s / T]++;
                if (tx_done !== 1'b0) done_seen++;
            end else begin
                check_eq($sformatf("%s tx_done at end", name), 32'(tx_done), 32'd1);
                check_eq($sformatf("%s line at end", name), 32'(tx_out), 32'd1);
            end
            if (s == 1) data_tx = mid_data;
            if (s == rel) start_tx = 1'b0;
            if (pulse_at >= 0 && s == pulse_at) start_tx = 1'b1;
            if (pulse_at >= 0 && s == pulse_at + 2) start_tx = 1'b0;
        end
        for (int k = 0; k < NBITS; k++)
            check_eq($sformatf("%s slot%0d cycles", name, k), 32'(good[k]), 32'(T));
        check_eq($sformatf("%s early tx_done", name), 32'(done_seen), 32'd0);
    endtask

    task automatic idle_check(input string name, input int n);
        int good;
        good = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (tx_out === 1'b1 && tx_done === 1'b0) good++;
        end
        check_eq(name, 32'(good), 32'(n));
    endtask

    initial begin
        // Reset held for two cycles
        rst = 1'b0;
        tick();
        tick();
        check_eq("reset tx_out", 32'(tx_out), 32'd1);
        check_eq("reset tx_done", 32'(tx_done), 32'd0);
        rst = 1'b1;
        idle_check("idle after reset", 3 * T);

        send_frame("f55", 8'h55, 4, 8'h55, -1);
        idle_check("idle after f55", 2 * T);

        // Back-to-back with start_tx held: second frame starts after one idle cycle
        send_frame("f00", 8'h00, -1, 8'hFF, -1);
        send_frame("fFF", 8'hFF, 0, 8'hFF, -1);
        idle_check("idle after fFF", 2 * T);

        // Mid-frame data change and request pulse are ignored
        send_frame("f96", 8'h96, 0, 8'h3C, 3 * T + 2);
        idle_check("no extra frame", 3 * T);

        // Reset during data bit 3 aborts the frame
        data_tx  = 8'h00;
        start_tx = 1'b1;
        tick();
        start_tx = 1'b0;
        for (int i = 0; i < 4 * T + 2; i++) tick();
        check_eq("abort pre-reset line", 32'(tx_out), 32'd0);
        rst = 1'b0;
        tick();
        check_eq("abort tx_out", 32'(tx_out), 32'd1);
        check_eq("abort tx_done", 32'(tx_done), 32'd0);
        rst = 1'b1;
        idle_check("abort stays idle", 8 * T);
        send_frame("fA5", 8'hA5, 0, 8'hA5, -1);
        idle_check("idle after fA5", 2 * T);

        // 0x07 has odd weight: parity slot is 1 when enabled
        send_frame("f07", 8'h07, 0, 8'h07, -1);
        idle_check("idle after f07", 2 * T);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
